react_test_ctrl: RTL and testbench
==================================

# react_test_ctrl

Sequencer for the reaction-time benchmark mode. It runs a fixed number of timed trials: random pre-stimulus delay, stimulus on, measure the press latency in milliseconds. It flags presses that come too early and produces the average over all trials. It sits below the main-menu FSM and is enabled while the selected mode is "react". It drives the VGA and hex-display datapaths through status and result outputs.

## Interface
- CLK_HZ, 50_000_000: clock frequency, used to derive the 1 ms tick.
- MIN_DELAY_MS, 1000: minimum pre-stimulus delay.
- RAND_BITS, 11: width of the random delay addend, giving an extra 0..2^RAND_BITS-1 ms.
- NUM_TRIALS, 5: number of scored trials per run, 1..7.
- TIMEOUT_MS, 9999: saturation value for a single reaction time.
- clk, input, 1: system clock.
- iResetn, input, 1: asynchronous, active-low reset.
- iEnable, input, 1: high while the react mode is selected.
- iPress, input, 1: player button level, synchronous to clk.
- oState, output, 3: current state encoding, for the display datapath.
- oStimulus, output, 1: high in STIM (screen shows "press now").
- oTooSoon, output, 1: high in EARLY.
- oReactMs, output, 14: last recorded reaction time.
- oTrial, output, 3: number of scored trials completed.
- oResultValid, output, 1: 1-cycle pulse when a new oReactMs is recorded.
- oAvgMs, output, 14: average of the scored trials, valid while oDone is high.
- oDone, output, 1: high in DONE.

## Operation
- Press event = iPress & ~press_q, where press_q is iPress registered. Only rising edges count; holding the button never re-triggers.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11, seed 16'hACE1 on reset, advances every cycle. On entry to DELAY, target = MIN_DELAY_MS + lfsr[RAND_BITS-1:0].
- ms counter: counts 1 ms ticks. It is cleared, along with the prescaler, on entry to DELAY and on entry to STIM.
- States:
  - IDLE: iEnable -> READY.
  - READY: press -> DELAY.
  - DELAY: press -> EARLY; ms count == target -> STIM.
  - STIM: press -> RESULT, recording the ms count; count == TIMEOUT_MS -> RESULT, recording TIMEOUT_MS.
  - RESULT: on entry, oReactMs updated, sum += value, trial++, oResultValid pulses. Press -> DELAY if trial < NUM_TRIALS, else DIVIDE.
  - EARLY: the trial is not scored. Press -> DELAY.
  - DIVIDE: quotient = sum / NUM_TRIALS by repeated subtraction, one subtract per cycle; remainder is truncated. Exits to DONE when sum < NUM_TRIALS.
  - DONE: press -> READY, with trial, sum and oAvgMs cleared.
- iEnable low in any state -> IDLE at the next edge. trial, sum, ms counter and prescaler are cleared; oReactMs is held.
- Widths:
  - sum is 17 bits (7 x 9999 fits).
  - ms counter saturates at TIMEOUT_MS.
  - The reaction value is the number of whole ms ticks since stimulus onset (truncated).
- Simultaneous events:
  - Press in the same cycle the DELAY target is reached -> EARLY.
  - Press in the same cycle the STIM timeout is reached -> RESULT with the current count.
  - iEnable low beats any press.

## Timing
- Reset values: state IDLE, every output 0, oState = IDLE code, LFSR = 16'hACE1.
- Press latency: iPress first sampled high at edge N; the state changes at edge N+1.
- STIM -> RESULT: oReactMs and oResultValid are valid in the first RESULT cycle. oResultValid is high for exactly that one cycle.
- The tick fires every CLK_HZ/1000 cycles. The first tick after counter clear comes a full period later.
- DIVIDE latency: floor(sum/NUM_TRIALS)+1 cycles, at most 10000.
- oStimulus asserts in the cycle after the target is reached and deasserts with the STIM exit.
- Asynchronous reset mid-run returns to IDLE immediately. No result pulse is emitted.

## Structure
- Shared header react_defs.vh holds:
  - the state codes IDLE=0, READY=1, DELAY=2, STIM=3, RESULT=4, EARLY=5, DIVIDE=6, DONE=7, used by the display datapath;
  - the LFSR seed and taps.
- Sub-module ms_timebase (prescaler): inputs clk, iResetn, iClear; output oTick, a 1-cycle pulse every CLK_HZ/1000 cycles.
- The FSM, LFSR, ms counter, accumulator and divider live in react_test_ctrl.

## Test plan
Bench parameters: CLK_HZ=4000 (4 cycles/ms), MIN_DELAY_MS=10, RAND_BITS=3, NUM_TRIALS=5, TIMEOUT_MS=50.

- Single trial: enable, press, wait for oStimulus, press 12 ms after onset -> oReactMs=12 and one oResultValid pulse. The measured delay is within 10..17 ms and matches lfsr[2:0].
- Early press: press 3 ms into DELAY -> oTooSoon=1, oTrial unchanged. A further press -> DELAY with a new target.
- Timeout: no press in STIM -> RESULT after 50 ms, oReactMs=50.
- Full run: trials of 10, 20, 30, 40, 52 -> after DIVIDE, oDone=1 and oAvgMs=30. The fifth trial saturates to 50, so the sum is 150.
- Held button: iPress held high across READY -> DELAY; no EARLY until it is released and pressed again.
- Abort: iEnable dropped in STIM -> IDLE next cycle, oStimulus=0, oTrial=0. Async reset mid-DIVIDE -> all outputs 0.

Source files
------------

// File: rtl/react_test_ctrl_pkg.sv
// rtl/react_test_ctrl_pkg.sv - shared state codes and LFSR constants for the reaction-time sequencer
// The state codes are also decoded by the display datapath, so their values are fixed.
package react_test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READY  = 3'd1,
    ST_DELAY  = 3'd2,
    ST_STIM   = 3'd3,
    ST_RESULT = 3'd4,
    ST_EARLY  = 3'd5,
    ST_DIVIDE = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // 16-bit Fibonacci LFSR, taps 16/14/13/11 (bit indices 15/13/12/10).
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/react_test_ctrl_if.sv
// rtl/react_test_ctrl_if.sv - player/menu inputs and status/result outputs of the reaction-time sequencer
// master: the menu side driving iEnable/iPress and reading status.
// slave : the sequencer itself.
interface react_test_ctrl_if;
  logic        iEnable;
  logic        iPress;
  logic [2:0]  oState;
  logic        oStimulus;
  logic        oTooSoon;
  logic [13:0] oReactMs;
  logic [2:0]  oTrial;
  logic        oResultValid;
  logic [13:0] oAvgMs;
  logic        oDone;

  modport master (
    output iEnable, iPress,
    input  oState, oStimulus, oTooSoon, oReactMs, oTrial, oResultValid, oAvgMs, oDone
  );

  modport slave (
    input  iEnable, iPress,
    output oState, oStimulus, oTooSoon, oReactMs, oTrial, oResultValid, oAvgMs, oDone
  );
endinterface

// File: rtl/react_test_ctrl_ms_timebase.sv
// rtl/react_test_ctrl_ms_timebase.sv - 1 ms tick prescaler with synchronous clear
// Ports: clk, iResetn (async active-low), iClear (restart the period),
//        oTick (1-cycle pulse every CLK_HZ/1000 cycles).
// After a clear the first tick comes a full period later.
module ms_timebase #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic iResetn,
  input  logic iClear,
  output logic oTick
);
  localparam int PERIOD = CLK_HZ / 1000;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last  = (cnt == CW'(PERIOD - 1));
  assign oTick = last & ~iClear;

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn)          cnt <= '0;
    else if (iClear || last) cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/react_test_ctrl.sv
// rtl/react_test_ctrl.sv - reaction-time benchmark sequencer (delay, stimulus, latency, average)
// Ports: clk, iResetn (async active-low), bus (react_test_ctrl_if.slave):
//   iEnable/iPress in; oState, oStimulus, oTooSoon, oReactMs, oTrial,
//   oResultValid, oAvgMs, oDone out.
module react_test_ctrl
  import react_test_ctrl_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 11,
  parameter int NUM_TRIALS   = 5,
  parameter int TIMEOUT_MS   = 9999
) (
  input  logic           clk,
  input  logic           iResetn,
  react_test_ctrl_if.slave bus
);
  state_t      state, nxt;
  logic        press_q, press_evt;
  logic [15:0] lfsr;
  logic [13:0] ms_cnt, target, react_ms, quot;
  logic [16:0] sum;
  logic [2:0]  trial;
  logic        result_valid, stim, too_soon, done;
  logic        tick, clr_time, en;

  assign en = bus.iEnable;

  ms_timebase #(.CLK_HZ(CLK_HZ)) u_timebase (
    .clk     (clk),
    .iResetn (iResetn),
    .iClear  (clr_time),
    .oTick   (tick)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (en) nxt = ST_READY;
      ST_READY:  if (press_evt) nxt = ST_DELAY;
      // A press on the same cycle the target is reached still counts as early.
      ST_DELAY:  if (press_evt) nxt = ST_EARLY;
                 else if (ms_cnt == target) nxt = ST_STIM;
      ST_STIM:   if (press_evt || ms_cnt == 14'(TIMEOUT_MS)) nxt = ST_RESULT;
      ST_RESULT: if (press_evt) nxt = (trial < 3'(NUM_TRIALS)) ? ST_DELAY : ST_DIVIDE;
      ST_EARLY:  if (press_evt) nxt = ST_DELAY;
      ST_DIVIDE: if (sum < 17'(NUM_TRIALS)) nxt = ST_DONE;
      ST_DONE:   if (press_evt) nxt = ST_READY;
    endcase
    if (!en) nxt = ST_IDLE;
  end

  // The prescaler restarts on the same edge the ms counter is cleared.
  assign clr_time = !en || ((nxt != state) && (nxt == ST_DELAY || nxt == ST_STIM));

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state        <= ST_IDLE;
      press_q      <= 1'b0;
      press_evt    <= 1'b0;
      lfsr         <= LFSR_SEED;
      ms_cnt       <= '0;
      target       <= '0;
      react_ms     <= '0;
      quot         <= '0;
      sum          <= '0;
      trial        <= '0;
      result_valid <= 1'b0;
      stim         <= 1'b0;
      too_soon     <= 1'b0;
      done         <= 1'b0;
    end else begin
      // Registering the edge detect puts one cycle between the sampled press and the state change.
      press_q      <= bus.iPress;
      press_evt    <= bus.iPress & ~press_q;
      lfsr         <= lfsr_next(lfsr);
      state        <= nxt;
      stim         <= (nxt == ST_STIM);
      too_soon     <= (nxt == ST_EARLY);
      done         <= (nxt == ST_DONE);
      result_valid <= 1'b0;

      if (clr_time) ms_cnt <= '0;
      else if (tick && ms_cnt < 14'(TIMEOUT_MS)) ms_cnt <= ms_cnt + 14'd1;

      if (state != ST_DELAY && nxt == ST_DELAY)
        target <= 14'(MIN_DELAY_MS) + 14'(lfsr[RAND_BITS-1:0]);

      // On timeout ms_cnt already equals TIMEOUT_MS, so one path records both cases.
      if (state == ST_STIM && nxt == ST_RESULT) begin
        react_ms     <= ms_cnt;
        sum          <= sum + 17'(ms_cnt);
        trial        <= trial + 3'd1;
        result_valid <= 1'b1;
      end

      if (state == ST_RESULT && nxt == ST_DIVIDE) quot <= '0;

      if (state == ST_DIVIDE && nxt == ST_DIVIDE) begin
        sum  <= sum - 17'(NUM_TRIALS);
        quot <= quot + 14'd1;
      end

      if ((state == ST_DONE && nxt == ST_READY) || !en) begin
        trial <= '0;
        sum   <= '0;
        quot  <= '0;
      end
    end
  end

  assign bus.oState       = state;
  assign bus.oStimulus    = stim;
  assign bus.oTooSoon     = too_soon;
  assign bus.oReactMs     = react_ms;
  assign bus.oTrial       = trial;
  assign bus.oResultValid = result_valid;
  assign bus.oAvgMs       = quot;
  assign bus.oDone        = done;
endmodule

// File: tb/tb_react_test_ctrl.sv
// tb/tb_react_test_ctrl.sv - directed self-checking bench for react_test_ctrl (4 cycles per ms)
module tb_react_test_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  react_test_ctrl_if bus ();

  react_test_ctrl #(
    .CLK_HZ(4000), .MIN_DELAY_MS(10), .RAND_BITS(3), .NUM_TRIALS(5), .TIMEOUT_MS(50)
  ) dut (
    .clk     (clk),
    .iResetn (rst_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tgt;
  logic [15:0] lfsr_m, lfsr_prev;

  // Reference LFSR: value before the most recent edge gives the target chosen on that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_press();
    bus.iPress = 1'b1;
    @(negedge clk);
    bus.iPress = 1'b0;
    @(negedge clk);
  endtask

  task automatic enter_delay();
    do_press();
    chk("enter_delay_state", 32'(bus.oState), 2);
    tgt = 10 + int'(lfsr_prev[2:0]);
  endtask

  task automatic wait_stim();
    int c;
    c = 0;
    while (!bus.oStimulus && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk("stim_latency", c, 4 * tgt + 1);
    chk("delay_in_range", 32'(((c - 1) / 4 >= 10) && ((c - 1) / 4 <= 17)), 1);
  endtask

  task automatic run_trial(input int m, input int exp_ms);
    int c;
    wait_stim();
    if (m < 50) begin
      repeat (4 * m + 1) @(negedge clk);
      do_press();
    end
    c = 0;
    while (!bus.oResultValid && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (m >= 50) chk("timeout_latency", c, 201);
    else         chk("result_latency", c, 0);
    chk("react_ms", 32'(bus.oReactMs), exp_ms);
    chk("result_state", 32'(bus.oState), 4);
    @(negedge clk);
    chk("valid_one_cycle", 32'(bus.oResultValid), 0);
  endtask

  initial begin
    int c;
    rst_n       = 1'b0;
    bus.iEnable = 1'b0;
    bus.iPress  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(bus.oState), 0);
    chk("rst_outputs", {bus.oStimulus, bus.oTooSoon, bus.oResultValid, bus.oDone, bus.oTrial}, 0);
    chk("rst_react_avg", {bus.oReactMs, bus.oAvgMs}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single trial, press 12 ms after onset.
    bus.iEnable = 1'b1;
    @(negedge clk);
    chk("ready_state", 32'(bus.oState), 1);
    enter_delay();
    run_trial(12, 12);
    chk("trial_after_1", 32'(bus.oTrial), 1);

    // Timeout trial.
    enter_delay();
    run_trial(99, 50);
    chk("trial_after_2", 32'(bus.oTrial), 2);

    // Early press 3 ms into the delay, then retry.
    enter_delay();
    repeat (12) @(negedge clk);
    do_press();
    chk("early_state", 32'(bus.oState), 5);
    chk("early_flag", 32'(bus.oTooSoon), 1);
    chk("early_trial", 32'(bus.oTrial), 2);
    enter_delay();
    chk("early_flag_clear", 32'(bus.oTooSoon), 0);
    wait_stim();

    // Abort from STIM.
    bus.iEnable = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(bus.oState), 0);
    chk("abort_stim", 32'(bus.oStimulus), 0);
    chk("abort_trial", 32'(bus.oTrial), 0);
    chk("abort_react_held", 32'(bus.oReactMs), 50);

    // Held button across READY -> DELAY must not trigger EARLY.
    bus.iEnable = 1'b1;
    @(negedge clk);
    bus.iPress = 1'b1;
    repeat (2) @(negedge clk);
    chk("held_delay", 32'(bus.oState), 2);
    repeat (10) @(negedge clk);
    chk("held_still_delay", 32'(bus.oState), 2);
    bus.iPress = 1'b0;
    @(negedge clk);
    do_press();
    chk("repress_early", 32'(bus.oState), 5);

    // Full run: 10, 20, 30, 40, 52 (saturates to 50) -> average 30.
    enter_delay();
    run_trial(10, 10);
    enter_delay();
    run_trial(20, 20);
    enter_delay();
    run_trial(30, 30);
    enter_delay();
    run_trial(40, 40);
    enter_delay();
    run_trial(52, 50);
    chk("trial_after_5", 32'(bus.oTrial), 5);
    do_press();
    chk("divide_state", 32'(bus.oState), 6);
    c = 0;
    while (!bus.oDone && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("divide_latency", c, 31);
    chk("done_state", 32'(bus.oState), 7);
    chk("avg_ms", 32'(bus.oAvgMs), 30);
    do_press();
    chk("restart_state", 32'(bus.oState), 1);
    chk("restart_cleared", {bus.oAvgMs, bus.oTrial, bus.oDone}, 0);

    // Second run of 10 ms trials, reset during DIVIDE.
    enter_delay();
    run_trial(10, 10);
    for (int i = 0; i < 4; i++) begin
      enter_delay();
      run_trial(10, 10);
    end
    do_press();
    chk("divide2_state", 32'(bus.oState), 6);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.oState), 0);
    chk("arst_outputs", {bus.oStimulus, bus.oTooSoon, bus.oResultValid, bus.oDone, bus.oTrial}, 0);
    chk("arst_react_avg", {bus.oReactMs, bus.oAvgMs}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
